fifo_sync_level_rx: RTL and testbench

- Single-clock, parametrised RX data FIFO for the I2C/APB datapath.
- Buffers received bytes between the I2C shift logic (writer) and the APB register read path (reader).
- Adds features beyond the basic RX FIFO: selectable read mode, occupancy level, programmable almost-full/almost-empty, flush, and sticky overflow/underflow status.

---
 rtl/fifo_sync_level_rx_if.sv | 27 ++
 rtl/fifo_sync_level_rx.sv | 128 ++++++++++++
 tb/tb_fifo_sync_level_rx.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_sync_level_rx_if.sv
// Read/write handshake bundle between the I2C shift logic, the APB read path and the RX FIFO.
// The master drives the write and read requests; the slave (FIFO) returns the read data.
interface fifo_sync_level_rx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  write_en_rx;
    logic [DATA_WIDTH-1:0] write_data_rx;
    logic                  read_en_rx;
    logic [DATA_WIDTH-1:0] read_data_rx;
    logic                  read_valid_rx;

    modport master (
        output write_en_rx,
        output write_data_rx,
        output read_en_rx,
        input  read_data_rx,
        input  read_valid_rx
    );

    modport slave (
        input  write_en_rx,
        input  write_data_rx,
        input  read_en_rx,
        output read_data_rx,
        output read_valid_rx
    );
endinterface

// File: rtl/fifo_sync_level_rx.sv
// Single-clock RX byte FIFO with occupancy level, programmable almost flags,
// flush, sticky overflow/underflow, and standard or fall-through read mode.
module fifo_sync_level_rx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned FWFT       = 0
) (
    input  logic                  clk_rx,
    input  logic                  reset_rx,
    input  logic                  flush_rx,
    fifo_sync_level_rx_if.slave   rx_if,
    input  logic [ADDR_WIDTH:0]   almost_full_thr_rx,
    input  logic [ADDR_WIDTH:0]   almost_empty_thr_rx,
    input  logic                  clear_status_rx,
    output logic                  full_rx,
    output logic                  empty_rx,
    output logic                  almost_full_rx,
    output logic                  almost_empty_rx,
    output logic [ADDR_WIDTH:0]   level_rx,
    output logic                  overflow_rx,
    output logic                  underflow_rx
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam int unsigned AW    = (ADDR_WIDTH > 0) ? ADDR_WIDTH : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [AW-1:0]         wr_addr;
    logic [AW-1:0]         rd_addr;
    logic                  write_acc;
    logic                  read_acc;
    logic                  overflow_set;
    logic                  underflow_set;
    logic                  unused_ptr_msb;

    // Occupancy flags all derive from the registered level.
    assign full_rx         = (level_rx == PTR_W'(DEPTH));
    assign empty_rx        = (level_rx == '0);
    assign almost_full_rx  = (level_rx >= almost_full_thr_rx);
    assign almost_empty_rx = (level_rx <= almost_empty_thr_rx);

    // Flush drops both requests, so neither is accepted nor flagged.
    assign write_acc     = rx_if.write_en_rx & ~full_rx  & ~flush_rx;
    assign read_acc      = rx_if.read_en_rx  & ~empty_rx & ~flush_rx;
    assign overflow_set  = rx_if.write_en_rx & full_rx   & ~flush_rx;
    assign underflow_set = rx_if.read_en_rx  & empty_rx  & ~flush_rx;

    if (ADDR_WIDTH > 0) begin : g_addr
        assign wr_addr = wr_ptr[AW-1:0];
        assign rd_addr = rd_ptr[AW-1:0];
    end else begin : g_addr_single
        assign wr_addr = '0;
        assign rd_addr = '0;
    end

    // Level is tracked directly, so the pointer MSBs only serve the wrap.
    assign unused_ptr_msb = wr_ptr[PTR_W-1] ^ rd_ptr[PTR_W-1];

    always_ff @(posedge clk_rx) begin
        if (reset_rx) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_rx <= '0;
        end else if (flush_rx) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_rx <= '0;
        end else begin
            if (write_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (read_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({write_acc, read_acc})
                2'b10:   level_rx <= level_rx + PTR_W'(1);
                2'b01:   level_rx <= level_rx - PTR_W'(1);
                default: level_rx <= level_rx;
            endcase
        end
    end

    // Storage has no reset; stale words are never exposed as valid.
    always_ff @(posedge clk_rx) begin
        if (!reset_rx && write_acc) begin
            mem[wr_addr] <= rx_if.write_data_rx;
        end
    end

    // Sticky status: a new event in the same cycle overrides a clear.
    always_ff @(posedge clk_rx) begin
        if (reset_rx) begin
            overflow_rx  <= 1'b0;
            underflow_rx <= 1'b0;
        end else begin
            overflow_rx  <= overflow_set  | (overflow_rx  & ~clear_status_rx);
            underflow_rx <= underflow_set | (underflow_rx & ~clear_status_rx);
        end
    end

    if (FWFT == 0) begin : g_std_read
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        always_ff @(posedge clk_rx) begin
            if (reset_rx) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else if (flush_rx) begin
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= read_acc;
                if (read_acc) begin
                    rd_data_q <= mem[rd_addr];
                end
            end
        end

        assign rx_if.read_data_rx  = rd_data_q;
        assign rx_if.read_valid_rx = rd_valid_q;
    end else begin : g_fwft_read
        // Head word is presented continuously; read_en acts as the acknowledge.
        assign rx_if.read_data_rx  = mem[rd_addr];
        assign rx_if.read_valid_rx = ~empty_rx;
    end
endmodule

// File: tb/tb_fifo_sync_level_rx.sv
// Drives a standard-mode and a fall-through FIFO with identical stimulus and
// compares both against a queue-based reference model.
module tb_fifo_sync_level_rx;
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          we = 1'b0;
    logic [DW-1:0] wd = '0;
    logic          re = 1'b0;
    logic          clr = 1'b0;
    logic [AW:0]   afthr = 4'd6;
    logic [AW:0]   aethr = 4'd2;

    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic [AW:0]   s_level;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [AW:0]   f_level;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] q[$];
    bit            m_ovf, m_udf, m_rdv;
    logic [DW-1:0] m_rdd;

    fifo_sync_level_rx_if #(.DATA_WIDTH(DW)) if_std ();
    fifo_sync_level_rx_if #(.DATA_WIDTH(DW)) if_ft ();

    assign if_std.write_en_rx   = we;
    assign if_std.write_data_rx = wd;
    assign if_std.read_en_rx    = re;
    assign if_ft.write_en_rx    = we;
    assign if_ft.write_data_rx  = wd;
    assign if_ft.read_en_rx     = re;

    fifo_sync_level_rx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0)) u_std (
        .clk_rx(clk), .reset_rx(rst), .flush_rx(flush), .rx_if(if_std),
        .almost_full_thr_rx(afthr), .almost_empty_thr_rx(aethr),
        .clear_status_rx(clr), .full_rx(s_full), .empty_rx(s_empty),
        .almost_full_rx(s_af), .almost_empty_rx(s_ae), .level_rx(s_level),
        .overflow_rx(s_ovf), .underflow_rx(s_udf)
    );

    fifo_sync_level_rx #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1)) u_ft (
        .clk_rx(clk), .reset_rx(rst), .flush_rx(flush), .rx_if(if_ft),
        .almost_full_thr_rx(afthr), .almost_empty_thr_rx(aethr),
        .clear_status_rx(clr), .full_rx(f_full), .empty_rx(f_empty),
        .almost_full_rx(f_af), .almost_empty_rx(f_ae), .level_rx(f_level),
        .overflow_rx(f_ovf), .underflow_rx(f_udf)
    );

    always #5 clk = ~clk;

    // Reference model: queue contents plus sticky flags and the registered read word.
    task automatic model_step();
        bit mfull;
        bit mempty;
        bit racc;
        bit wacc;
        mfull  = (q.size() == DEPTH);
        mempty = (q.size() == 0);
        if (rst) begin
            q.delete();
            m_ovf = 0; m_udf = 0; m_rdv = 0; m_rdd = '0;
        end else if (flush) begin
            q.delete();
            m_rdv = 0;
            if (clr) begin m_ovf = 0; m_udf = 0; end
        end else begin
            racc  = re && !mempty;
            wacc  = we && !mfull;
            m_ovf = (we && mfull) || (m_ovf && !clr);
            m_udf = (re && mempty) || (m_udf && !clr);
            m_rdv = racc;
            if (racc) m_rdd = q.pop_front();
            if (wacc) q.push_back(wd);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_flags();
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b1; wd = 8'h3C; re = 1'b1;
        tick(); tick();
        checks++; if (s_level !== 4'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", s_level); end
        checks++; if (s_empty !== 1'b1 || s_full !== 1'b0) begin failures++; $display("FAIL reset_empty_full got=%b%b exp=10", s_empty, s_full); end
        checks++; if (s_ovf !== 1'b0 || s_udf !== 1'b0) begin failures++; $display("FAIL reset_sticky got=%b%b exp=00", s_ovf, s_udf); end
        checks++; if (if_std.read_valid_rx !== 1'b0 || if_std.read_data_rx !== 8'h00) begin failures++; $display("FAIL reset_read got=%b/%h exp=0/00", if_std.read_valid_rx, if_std.read_data_rx); end
        checks++; if (if_ft.read_valid_rx !== 1'b0) begin failures++; $display("FAIL reset_ft_valid got=%b exp=0", if_ft.read_valid_rx); end
        checks++; if (s_ae !== 1'b1 || s_af !== 1'b0) begin failures++; $display("FAIL reset_almost got=ae%b af%b exp=ae1 af0", s_ae, s_af); end
        afthr = 4'd0; #1;
        checks++; if (s_af !== 1'b1) begin failures++; $display("FAIL reset_af_thr0 got=%b exp=1", s_af); end
        afthr = 4'd6;
        we = 1'b0; re = 1'b0; rst = 1'b0;
        tick();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; wd = 8'(8'h11 + i);
            tick();
            checks++; if (s_level !== 4'(i + 1)) begin failures++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, s_level, i + 1); end
            checks++; if (if_ft.read_valid_rx !== 1'b1 || if_ft.read_data_rx !== 8'h11) begin failures++; $display("FAIL fill_ft_head[%0d] got=%b/%h exp=1/11", i, if_ft.read_valid_rx, if_ft.read_data_rx); end
        end
        checks++; if (s_full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", s_full); end
        wd = 8'h99; tick(); we = 1'b0;
        checks++; if (s_ovf !== 1'b1 || s_level !== 4'd8) begin failures++; $display("FAIL overflow got=ovf%b lvl%0d exp=ovf1 lvl8", s_ovf, s_level); end
        for (int i = 0; i < 8; i++) begin
            re = 1'b1;
            tick();
            checks++; if (if_std.read_valid_rx !== 1'b1 || if_std.read_data_rx !== 8'(8'h11 + i)) begin failures++; $display("FAIL drain_std[%0d] got=%b/%h exp=1/%h", i, if_std.read_valid_rx, if_std.read_data_rx, 8'(8'h11 + i)); end
            if (i < 7) begin
                checks++; if (if_ft.read_data_rx !== 8'(8'h12 + i)) begin failures++; $display("FAIL drain_ft[%0d] got=%h exp=%h", i, if_ft.read_data_rx, 8'(8'h12 + i)); end
            end
        end
        re = 1'b0;
        checks++; if (s_empty !== 1'b1 || f_empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b%b exp=11", s_empty, f_empty); end
        tick();
        checks++; if (if_std.read_valid_rx !== 1'b0) begin failures++; $display("FAIL valid_pulse got=%b exp=0", if_std.read_valid_rx); end
        clear_flags();
    endtask

    task automatic test_underflow();
        re = 1'b1; tick(); re = 1'b0;
        checks++; if (s_udf !== 1'b1 || s_level !== 4'd0 || if_std.read_valid_rx !== 1'b0) begin failures++; $display("FAIL underflow got=udf%b lvl%0d v%b exp=udf1 lvl0 v0", s_udf, s_level, if_std.read_valid_rx); end
        clear_flags();
        checks++; if (s_udf !== 1'b0) begin failures++; $display("FAIL udf_clear got=%b exp=0", s_udf); end
        re = 1'b1; clr = 1'b1; tick(); re = 1'b0; clr = 1'b0;
        checks++; if (s_udf !== 1'b1 || f_udf !== 1'b1) begin failures++; $display("FAIL udf_set_wins got=%b%b exp=11", s_udf, f_udf); end
        clear_flags();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; wd = 8'($urandom); tick();
        end
        re = 1'b1;
        for (int i = 0; i < 24; i++) begin
            wd = 8'($urandom); tick();
            checks++; if (s_level !== 4'd4 || f_level !== 4'd4) begin failures++; $display("FAIL b2b_level[%0d] got=%0d/%0d exp=4", i, s_level, f_level); end
            checks++; if (if_std.read_valid_rx !== 1'b1 || if_std.read_data_rx !== m_rdd) begin failures++; $display("FAIL b2b_std[%0d] got=%b/%h exp=1/%h", i, if_std.read_valid_rx, if_std.read_data_rx, m_rdd); end
            checks++; if (if_ft.read_data_rx !== q[0]) begin failures++; $display("FAIL b2b_ft[%0d] got=%h exp=%h", i, if_ft.read_data_rx, q[0]); end
        end
        re = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wd = 8'($urandom); tick();
        end
        re = 1'b1; wd = 8'hEE; tick(); we = 1'b0; re = 1'b0;
        checks++; if (s_level !== 4'd7 || s_ovf !== 1'b1) begin failures++; $display("FAIL full_rw got=lvl%0d ovf%b exp=lvl7 ovf1", s_level, s_ovf); end
        checks++; if (if_std.read_data_rx !== m_rdd) begin failures++; $display("FAIL full_rw_data got=%h exp=%h", if_std.read_data_rx, m_rdd); end
        clear_flags();
    endtask

    task automatic test_thresholds();
        flush = 1'b1; tick(); flush = 1'b0;
        afthr = 4'd6; aethr = 4'd2;
        for (int i = 0; i <= 8; i++) begin
            #1;
            checks++; if (s_ae !== (i <= 2) || s_af !== (i >= 6)) begin failures++; $display("FAIL almost[%0d] got=ae%b af%b exp=ae%b af%b", i, s_ae, s_af, i <= 2, i >= 6); end
            if (i < 8) begin
                we = 1'b1; wd = 8'($urandom); tick(); we = 1'b0;
            end
        end
        afthr = 4'd15; aethr = 4'd9; #1;
        checks++; if (s_af !== 1'b0 || s_ae !== 1'b1) begin failures++; $display("FAIL thr_above_depth got=af%b ae%b exp=af0 ae1", s_af, s_ae); end
        afthr = 4'd6; aethr = 4'd2;
    endtask

    task automatic test_fwft();
        flush = 1'b1; tick(); flush = 1'b0;
        we = 1'b1; wd = 8'hA5; tick();
        checks++; if (if_ft.read_valid_rx !== 1'b1 || if_ft.read_data_rx !== 8'hA5) begin failures++; $display("FAIL ft_first got=%b/%h exp=1/a5", if_ft.read_valid_rx, if_ft.read_data_rx); end
        wd = 8'h5A; tick(); we = 1'b0;
        re = 1'b1; tick(); re = 1'b0;
        checks++; if (if_ft.read_valid_rx !== 1'b1 || if_ft.read_data_rx !== 8'h5A) begin failures++; $display("FAIL ft_ack got=%b/%h exp=1/5a", if_ft.read_valid_rx, if_ft.read_data_rx); end
        checks++; if (if_std.read_valid_rx !== 1'b1 || if_std.read_data_rx !== 8'hA5) begin failures++; $display("FAIL std_ack got=%b/%h exp=1/a5", if_std.read_valid_rx, if_std.read_data_rx); end
    endtask

    task automatic test_flush_reset();
        flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            we = 1'b1; wd = 8'($urandom); tick();
        end
        flush = 1'b1; tick(); flush = 1'b0; we = 1'b0;
        checks++; if (s_level !== 4'd0 || s_empty !== 1'b1 || s_ovf !== 1'b0 || f_empty !== 1'b1) begin failures++; $display("FAIL flush5 got=lvl%0d e%b ovf%b fe%b exp=lvl0 e1 ovf0 fe1", s_level, s_empty, s_ovf, f_empty); end
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; wd = 8'($urandom); tick();
        end
        flush = 1'b1; tick(); flush = 1'b0; we = 1'b0;
        checks++; if (s_ovf !== 1'b0 || s_level !== 4'd0) begin failures++; $display("FAIL flush_full got=ovf%b lvl%0d exp=ovf0 lvl0", s_ovf, s_level); end
        re = 1'b1; flush = 1'b1; tick(); re = 1'b0; flush = 1'b0;
        checks++; if (s_udf !== 1'b0) begin failures++; $display("FAIL flush_empty_read got=%b exp=0", s_udf); end
        for (int i = 0; i < 3; i++) begin
            we = 1'b1; wd = 8'($urandom); re = (i == 2); tick();
        end
        rst = 1'b1; tick(); rst = 1'b0; we = 1'b0; re = 1'b0;
        checks++; if (s_level !== 4'd0 || s_empty !== 1'b1 || s_full !== 1'b0 || f_level !== 4'd0) begin failures++; $display("FAIL midreset_level got=%0d/%0d e%b f%b exp=0/0 e1 f0", s_level, f_level, s_empty, s_full); end
        checks++; if (if_std.read_valid_rx !== 1'b0 || if_std.read_data_rx !== 8'h00 || if_ft.read_valid_rx !== 1'b0) begin failures++; $display("FAIL midreset_read got=%b/%h/%b exp=0/00/0", if_std.read_valid_rx, if_std.read_data_rx, if_ft.read_valid_rx); end
    endtask

    task automatic test_random();
        int exp_level;
        for (int n = 0; n < 400; n++) begin
            if (n % 32 == 0) begin
                afthr = 4'($urandom_range(0, 15));
                aethr = 4'($urandom_range(0, 15));
            end
            rst   = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 19) == 0);
            clr   = !flush && ($urandom_range(0, 7) == 0);
            we    = ($urandom_range(0, 99) < 60);
            re    = ($urandom_range(0, 99) < 50);
            wd    = 8'($urandom);
            tick();
            exp_level = q.size();
            checks++; if (s_level !== 4'(exp_level) || f_level !== 4'(exp_level)) begin failures++; $display("FAIL rnd_level[%0d] got=%0d/%0d exp=%0d", n, s_level, f_level, exp_level); end
            checks++; if (s_full !== (exp_level == DEPTH) || s_empty !== (exp_level == 0)) begin failures++; $display("FAIL rnd_fe[%0d] got=%b%b exp=%b%b", n, s_full, s_empty, exp_level == DEPTH, exp_level == 0); end
            checks++; if (s_af !== (exp_level >= int'(afthr)) || s_ae !== (exp_level <= int'(aethr))) begin failures++; $display("FAIL rnd_almost[%0d] got=af%b ae%b lvl%0d thr%0d/%0d", n, s_af, s_ae, exp_level, afthr, aethr); end
            checks++; if (s_ovf !== m_ovf || s_udf !== m_udf || f_ovf !== m_ovf || f_udf !== m_udf) begin failures++; $display("FAIL rnd_sticky[%0d] got=%b%b/%b%b exp=%b%b", n, s_ovf, s_udf, f_ovf, f_udf, m_ovf, m_udf); end
            checks++; if (if_std.read_valid_rx !== m_rdv || if_std.read_data_rx !== m_rdd) begin failures++; $display("FAIL rnd_std[%0d] got=%b/%h exp=%b/%h", n, if_std.read_valid_rx, if_std.read_data_rx, m_rdv, m_rdd); end
            checks++; if (if_ft.read_valid_rx !== (exp_level != 0)) begin failures++; $display("FAIL rnd_ft_valid[%0d] got=%b exp=%b", n, if_ft.read_valid_rx, exp_level != 0); end
            if (exp_level != 0) begin
                checks++; if (if_ft.read_data_rx !== q[0]) begin failures++; $display("FAIL rnd_ft_data[%0d] got=%h exp=%h", n, if_ft.read_data_rx, q[0]); end
            end
        end
        rst = 1'b0; flush = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_underflow();
        test_back_to_back();
        test_thresholds();
        test_fwft();
        test_flush_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
